// File: rtl/decoder_pkg.sv
// Shared types for the scan decoder.
//   mode_t  : operating mode as seen on the 2-bit mode input
//   state_t : controller FSM state
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_DIRECT = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_SWEEP  = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_DIRECT = 3'd1,
        ST_SCAN   = 3'd2,
        ST_SWEEP  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Dwell down-counter for the scan decoder.
//   i_clk      : clock, rising edge
//   i_rst      : synchronous active-high reset, clears the count
//   i_load     : load i_load_val (takes priority over counting)
//   i_en       : count down by one (holds at zero)
//   i_load_val : reload value, already clamped to >= 1 by the caller
//   o_expire   : current cycle is the last one of the dwell
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_en,
    input  logic [DWELL_W-1:0] i_load_val,
    output logic               o_expire
);

    logic [DWELL_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - DWELL_W'(1);
        end
    end

    // A count of zero only exists straight after reset; treat it as expired
    // so a stray run state can never stall.
    assign o_expire = (r_count <= DWELL_W'(1));

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2**N decoder with direct, continuous-scan and single-sweep
// modes. Each scanned output is held for max(dwell,1) enabled cycles.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   en    : global enable; low blanks f and freezes idx / dwell counter
//   mode  : 00 off, 01 direct, 10 scan, 11 sweep
//   sel   : direct-mode select
//   dwell : cycles per index in scan/sweep (0 behaves as 1)
//   f     : one-hot or all-zero decode
//   idx   : binary index of the active output
//   valid : f is one-hot
//   done  : one-cycle pulse when a sweep completes
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_OFF    | outputs blank, idx held
// ST_DIRECT | f follows sel with one cycle latency
// ST_SCAN   | idx walks 0..N-1 and wraps, dwell per index
// ST_SWEEP  | idx walks 0..N-1 once
// ST_DONE   | sweep finished; waits for mode to leave 11
module scan_decoder
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [2**SEL_W-1:0]  f,
    output logic [SEL_W-1:0]     idx,
    output logic                 valid,
    output logic                 done
);

    localparam int               N        = 2**SEL_W;
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N - 1);

    state_t             r_state;
    logic [N-1:0]       r_f;
    logic [SEL_W-1:0]   r_idx;
    logic               r_valid;
    logic               r_done;

    mode_t              w_mode;
    state_t             w_state_nxt;
    logic               w_expire;
    logic               w_run;
    logic               w_entry;
    logic               w_stay;
    logic               w_step;
    logic               w_load;
    logic               w_tick;
    logic               w_show;
    logic [SEL_W-1:0]   w_idx_nxt;
    logic [N-1:0]       w_f_nxt;
    logic               w_done_nxt;
    logic [DWELL_W-1:0] w_dwell_eff;

    assign w_mode      = mode_t'(mode);
    assign w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_load),
        .i_en       (w_tick),
        .i_load_val (w_dwell_eff),
        .o_expire   (w_expire)
    );

    // Next state. Mode 11 only starts a sweep from outside SWEEP/DONE, so a
    // finished sweep needs mode to leave 11 before it can rerun.
    always_comb begin
        w_state_nxt = r_state;
        case (w_mode)
            MODE_OFF:    w_state_nxt = ST_OFF;
            MODE_DIRECT: w_state_nxt = ST_DIRECT;
            MODE_SCAN:   w_state_nxt = ST_SCAN;
            MODE_SWEEP: begin
                case (r_state)
                    ST_SWEEP: begin
                        if (en && w_expire && (r_idx == IDX_LAST))
                            w_state_nxt = ST_DONE;
                        else
                            w_state_nxt = ST_SWEEP;
                    end
                    ST_DONE: w_state_nxt = ST_DONE;
                    default: w_state_nxt = ST_SWEEP;
                endcase
            end
            default:     w_state_nxt = ST_OFF;
        endcase
    end

    // Next outputs and timer control, all keyed on the next state so a mode
    // change always wins over a coincident dwell expiry.
    always_comb begin
        w_run      = (w_state_nxt == ST_SCAN) || (w_state_nxt == ST_SWEEP);
        w_entry    = w_run && (w_state_nxt != r_state);
        w_stay     = w_run && (w_state_nxt == r_state);
        w_step     = w_stay && en && w_expire;
        w_load     = w_entry || w_step;
        w_tick     = w_stay && en && !w_expire;
        w_show     = en && (w_run || (w_state_nxt == ST_DIRECT));
        w_done_nxt = (r_state == ST_SWEEP) && (w_state_nxt == ST_DONE);

        w_idx_nxt = r_idx;
        if (w_entry)
            w_idx_nxt = '0;
        else if (w_step)
            w_idx_nxt = r_idx + SEL_W'(1);  // natural wrap in SCAN
        else if ((w_state_nxt == ST_DIRECT) && en)
            w_idx_nxt = sel;

        w_f_nxt = '0;
        if (w_show)
            w_f_nxt = N'(1) << w_idx_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_OFF;
            r_f     <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_f     <= w_f_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_show;
            r_done  <= w_done_nxt;
        end
    end

    assign f     = r_f;
    assign idx   = r_idx;
    assign valid = r_valid;
    assign done  = r_done;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder (SEL_W=4, DWELL_W=8).
module tb_scan_decoder;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  sel;
    logic [7:0]  dwell;
    logic [15:0] f;
    logic [3:0]  idx;
    logic        valid;
    logic        done;

    int n_checks;
    int n_fail;

    scan_decoder #(
        .SEL_W   (4),
        .DWELL_W (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .dwell (dwell),
        .f     (f),
        .idx   (idx),
        .valid (valid),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   exp_i;
        logic seen_done;
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        en    = 1'b1;
        mode  = 2'b10;
        sel   = 4'h0;
        dwell = 8'd5;

        // Reset overrides mode and en
        step();
        step();
        check_eq("rst_f", 32'(f), 32'h0);
        check_eq("rst_idx", 32'(idx), 32'h0);
        check_eq("rst_valid", 32'(valid), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        rst  = 1'b0;
        mode = 2'b00;
        step();
        check_eq("off_f", 32'(f), 32'h0);

        // DIRECT
        mode = 2'b01;
        sel  = 4'hA;
        step();
        check_eq("dir_a_f", 32'(f), 32'h0400);
        check_eq("dir_a_idx", 32'(idx), 32'hA);
        check_eq("dir_a_valid", 32'(valid), 32'h1);
        sel = 4'h3;
        step();
        check_eq("dir_3_f", 32'(f), 32'h0008);
        check_eq("dir_3_idx", 32'(idx), 32'h3);
        check_eq("dir_3_valid", 32'(valid), 32'h1);
        en  = 1'b0;
        sel = 4'h9;
        step();
        check_eq("dir_en0_f", 32'(f), 32'h0);
        check_eq("dir_en0_valid", 32'(valid), 32'h0);
        check_eq("dir_en0_idx", 32'(idx), 32'h3);

        // SCAN dwell=3: full lap plus wrap back to 0 on cycle 49
        en    = 1'b1;
        mode  = 2'b10;
        dwell = 8'd3;
        for (int k = 1; k <= 49; k++) begin
            step();
            exp_i = ((k - 1) / 3) % 16;
            check_eq($sformatf("scan_idx_%0d", k), 32'(idx), 32'(exp_i));
            check_eq($sformatf("scan_f_%0d", k), 32'(f), 32'(1) << exp_i);
        end
        check_eq("scan_valid", 32'(valid), 32'h1);
        check_eq("scan_done", 32'(done), 32'h0);

        // SWEEP dwell=0 behaves as dwell=1
        mode = 2'b00;
        step();
        check_eq("off2_f", 32'(f), 32'h0);
        mode  = 2'b11;
        dwell = 8'd0;
        for (int k = 0; k < 16; k++) begin
            step();
            check_eq($sformatf("sweep_idx_%0d", k), 32'(idx), 32'(k));
            check_eq($sformatf("sweep_f_%0d", k), 32'(f), 32'(1) << k);
            check_eq($sformatf("sweep_nodone_%0d", k), 32'(done), 32'h0);
        end
        step();
        check_eq("sweep_end_f", 32'(f), 32'h0);
        check_eq("sweep_end_valid", 32'(valid), 32'h0);
        check_eq("sweep_end_done", 32'(done), 32'h1);
        check_eq("sweep_end_idx", 32'(idx), 32'hF);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq($sformatf("sweep_hold_done_%0d", k), 32'(done), 32'h0);
            check_eq($sformatf("sweep_hold_f_%0d", k), 32'(f), 32'h0);
        end

        // en gating in SCAN, dwell=4: gap at idx=2 with 2 cycles left
        mode  = 2'b10;
        dwell = 8'd4;
        for (int k = 0; k < 10; k++) step();
        check_eq("gate_pre_idx", 32'(idx), 32'h2);
        check_eq("gate_pre_f", 32'(f), 32'h0004);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq($sformatf("gate_gap_f_%0d", k), 32'(f), 32'h0);
            check_eq($sformatf("gate_gap_valid_%0d", k), 32'(valid), 32'h0);
            check_eq($sformatf("gate_gap_idx_%0d", k), 32'(idx), 32'h2);
        end
        en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check_eq($sformatf("gate_res_idx_%0d", k), 32'(idx), 32'h2);
            check_eq($sformatf("gate_res_f_%0d", k), 32'(f), 32'h0004);
        end
        step();
        check_eq("gate_next_idx", 32'(idx), 32'h3);
        check_eq("gate_next_f", 32'(f), 32'h0008);

        // Reset in the middle of a sweep
        mode = 2'b00;
        step();
        mode  = 2'b11;
        dwell = 8'd1;
        for (int k = 0; k < 8; k++) step();
        check_eq("rsw_pre_idx", 32'(idx), 32'h7);
        check_eq("rsw_pre_f", 32'(f), 32'h0080);
        rst = 1'b1;
        step();
        check_eq("rsw_f", 32'(f), 32'h0);
        check_eq("rsw_idx", 32'(idx), 32'h0);
        check_eq("rsw_valid", 32'(valid), 32'h0);
        check_eq("rsw_done", 32'(done), 32'h0);
        rst  = 1'b0;
        mode = 2'b00;
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (done) seen_done = 1'b1;
        end
        check_eq("rsw_never_done", 32'(seen_done), 32'h0);
        check_eq("rsw_after_f", 32'(f), 32'h0);

        // Mode change on the last index's expiry beats the done pulse
        mode  = 2'b11;
        dwell = 8'd1;
        sel   = 4'h5;
        for (int k = 0; k < 16; k++) step();
        check_eq("prio_pre_idx", 32'(idx), 32'hF);
        check_eq("prio_pre_f", 32'(f), 32'h8000);
        mode = 2'b01;
        step();
        check_eq("prio_done", 32'(done), 32'h0);
        check_eq("prio_f", 32'(f), 32'h0020);
        check_eq("prio_idx", 32'(idx), 32'h5);
        check_eq("prio_valid", 32'(valid), 32'h1);
        step();
        check_eq("prio_done2", 32'(done), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 4, meaning select width; output width is 2**SEL_W (4 gives a 4-to-16 decoder).
REQ-002 SHALL have parameter DWELL_W, default 8, meaning dwell-counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port en, input, 1, global enable; while low f reads all-zero and counters freeze.
REQ-006 SHALL have port mode, input, 2: 00 OFF, 01 DIRECT, 10 SCAN (continuous), 11 SWEEP (single pass).
REQ-007 SHALL have port sel, input, SEL_W, binary select used in DIRECT mode.
REQ-008 SHALL have port dwell, input, DWELL_W, cycles each output is held in SCAN and SWEEP; 0 is treated as 1.
REQ-009 SHALL have port f, output, 2**SEL_W, registered one-hot (or all-zero) decode.
REQ-010 SHALL have port idx, output, SEL_W, registered binary index of the active output.
REQ-011 SHALL have port valid, output, 1, high exactly when f is one-hot.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at SWEEP completion.

Function
REQ-013 SHALL implement FSM states OFF, DIRECT, SCAN, SWEEP, DONE; state, f, idx, valid and done are all registered.
REQ-014 SHALL evaluate transitions each cycle: mode 00 to OFF; 01 to DIRECT; 10 to SCAN; 11 to SWEEP from any state except SWEEP and DONE.
REQ-015 SHALL hold DONE while mode is 11, so a new sweep requires mode to leave 11 and return.
REQ-016 SHALL, in OFF and DONE, drive f=0, valid=0 and hold idx.
REQ-017 SHALL, in DIRECT with en high, give f[sel]=1, idx=sel and valid=1 one cycle after sel is sampled (latency 1).
REQ-018 SHALL, on entry to SCAN or SWEEP, set idx=0, load the dwell counter from max(dwell,1), and assert f[0] on the entry cycle's following edge.
REQ-019 SHALL hold each index for exactly max(dwell,1) enabled cycles, then increment idx and reload the counter.
REQ-020 SHALL sample dwell only at each reload; mid-dwell changes take effect at the next reload.
REQ-021 SHALL, in SCAN, wrap idx from 2**SEL_W-1 to 0 with no gap cycle.
REQ-022 SHALL, in SWEEP, after the last index's dwell, go to DONE, drive f=0 and valid=0, and pulse done for one cycle on that same edge.
REQ-023 SHALL, with en low, drive f=0 and valid=0 the next cycle and freeze the dwell counter and idx; the FSM still follows mode.
REQ-024 SHALL, when en returns high, resume SCAN or SWEEP at the frozen idx with the remaining dwell.
REQ-025 SHALL give a mode change priority over a simultaneous dwell expiry: the new mode is taken and no increment or done occurs.
REQ-026 SHALL never drive more than one bit of f high in any cycle.

Reset
REQ-027 SHALL, with rst high at a clock edge, set state=OFF, f=0, idx=0, valid=0, done=0 and dwell counter=0, overriding en and mode.
REQ-028 SHALL, on reset mid-SCAN or mid-SWEEP, abort with no done pulse; after release, behaviour follows REQ-014 from the current mode.

Structure
REQ-029 SHALL place mode_t (2-bit enum of the four modes) and state_t (FSM enum) in shared package decoder_pkg.
REQ-030 SHALL implement the dwell down-counter, with load, enable and expire, as sub-module dwell_timer parametrised by DWELL_W.
REQ-031 SHALL be written as a single always_ff for state and outputs plus an always_comb for next-state; no latches.

Verification (SEL_W=4, DWELL_W=8)
REQ-032 SHALL test DIRECT: mode=01, en=1, sel=4'hA, then 4'h3 -> f=16'h0400 then 16'h0008, each 1 cycle after the select, with valid=1.
REQ-033 SHALL test SCAN: mode=10, dwell=3 -> idx runs 0,0,0,1,1,1,...,15,15,15,0; f[0] returns on cycle 49 after entry with no gap.
REQ-034 SHALL test SWEEP: mode=11, dwell=0 -> idx runs 0..15, one cycle each, then f=0 and a single done pulse; mode held at 11 gives no further activity.
REQ-035 SHALL test en gating: in SCAN, dwell=4, drop en for 5 cycles at idx=2 with 2 cycles left -> f=0 during the gap, then idx=2 held for 2 more cycles on resume.
REQ-036 SHALL test reset: assert rst during SWEEP at idx=7 -> next cycle f=0, idx=0, done never pulses.
REQ-037 SHALL test mode priority: switch mode 11 to 01 on the exact expiry cycle of idx=15 -> no done pulse; f=one-hot of sel next cycle.
